// File: rtl/event_window_3x3_if.sv
// Pixel-in / window-out bus of the 3x3 event window generator.
// The master drives pixels and frame starts; the slave returns windows and status.
interface event_window_3x3_if;
  logic       startFrame;
  logic       pixelValid;
  logic       pixelIn;
  logic [8:0] windowOut;
  logic       windowValid;
  logic [7:0] xAddress;
  logic [7:0] yAddress;
  logic       frameDone;
  logic       busy;

  modport master (
    output startFrame, pixelValid, pixelIn,
    input  windowOut, windowValid, xAddress, yAddress, frameDone, busy
  );

  modport slave (
    input  startFrame, pixelValid, pixelIn,
    output windowOut, windowValid, xAddress, yAddress, frameDone, busy
  );
endinterface

// File: rtl/event_window_3x3.sv
// Turns a raster stream of 1-bit event pixels into 3x3 windows around interior centres.
// Two row buffers plus a two-column shift register feed one registered window per accepted pixel.
module event_window_3x3 #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input  logic                clk,
  input  logic                reset,
  event_window_3x3_if.slave   bus
);

  localparam int         IDX_W    = $clog2(IMG_WIDTH);
  localparam logic [7:0] LAST_COL = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] LAST_ROW = 8'(IMG_HEIGHT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [7:0]           col;
  logic [7:0]           row;
  logic [IMG_WIDTH-1:0] lb0;
  logic [IMG_WIDTH-1:0] lb1;
  // Column vectors are indexed 0 = top (row r-2), 1 = middle, 2 = bottom (row r).
  logic [2:0]           sr_left;
  logic [2:0]           sr_mid;
  logic [2:0]           new_col;
  logic [IDX_W-1:0]     idx;
  logic                 accept;
  logic                 emit;
  logic                 last_pix;
  logic [8:0]           window_next;

  assign accept   = (state == RUN) && bus.pixelValid;
  assign idx      = col[IDX_W-1:0];
  assign new_col  = {bus.pixelIn, lb1[idx], lb0[idx]};
  assign emit     = accept && (col >= 8'd2) && (row >= 8'd2);
  assign last_pix = accept && (col == LAST_COL) && (row == LAST_ROW);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    window_next = '0;
    for (int dy = 0; dy < 3; dy++) begin
      window_next[3*dy]     = sr_left[dy];
      window_next[3*dy + 1] = sr_mid[dy];
      window_next[3*dy + 2] = new_col[dy];
    end
  end

  // NOTE: row buffers and column registers carry no reset; the c>=2 / r>=2 gate
  // guarantees stale bits never reach the output, and resetless storage maps to RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[idx] <= lb1[idx];
      lb1[idx] <= bus.pixelIn;
      sr_left  <= sr_mid;
      sr_mid   <= new_col;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      col             <= 8'd0;
      row             <= 8'd0;
      bus.windowOut   <= 9'd0;
      bus.windowValid <= 1'b0;
      bus.xAddress    <= 8'd0;
      bus.yAddress    <= 8'd0;
      bus.frameDone   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.windowValid <= emit;
      bus.frameDone   <= last_pix;
      if (emit) begin
        bus.windowOut <= window_next;
        bus.xAddress  <= col - 8'd1;
        bus.yAddress  <= row - 8'd1;
      end

      case (state)
        IDLE: begin
          if (bus.startFrame) begin
            state    <= RUN;
            col      <= 8'd0;
            row      <= 8'd0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == LAST_COL) begin
              col <= 8'd0;
              row <= (row == LAST_ROW) ? 8'd0 : row + 8'd1;
            end else begin
              col <= col + 8'd1;
            end
            if (last_pix) state <= DONE;
          end
        end
        DONE: begin
          // busy stays high through the frameDone cycle and drops on the way to IDLE.
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_window_3x3.sv
// Bench for event_window_3x3: a 5x5 instance and a 256x3 instance driven from per-frame
// vector tables, with expected windows queued at drive time and matched on windowValid.
module tb_event_window_3x3;

  typedef struct {
    bit         pix;
    bit         emit;
    logic [8:0] win;
    logic [7:0] x;
    logic [7:0] y;
    bit         last;
  } vec_t;

  typedef struct {
    logic [8:0] win;
    logic [7:0] x;
    logic [7:0] y;
    bit         done;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   win_cnt_a;
  int   win_cnt_b;
  logic [7:0] last_x_b;
  logic [7:0] last_y_b;

  bit   img [256][256];
  vec_t vecs[$];
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  event_window_3x3_if ifa ();
  event_window_3x3_if ifb ();

  event_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  event_window_3x3 #(.IMG_WIDTH(256), .IMG_HEIGHT(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference window built straight from the stored image, centred at (cx, cy).
  function automatic logic [8:0] model_win(input int cx, input int cy);
    logic [8:0] w;
    w = '0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        w[3*dy + dx] = img[cy - 1 + dy][cx - 1 + dx];
    return w;
  endfunction

  task automatic fill_img(input int w, input int h, input int mode);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        case (mode)
          0:       img[y][x] = 1'b1;
          1:       img[y][x] = (x == 2 && y == 2);
          default: img[y][x] = 1'($urandom_range(1, 0));
        endcase
  endtask

  task automatic build_vectors(input int w, input int h);
    vec_t v;
    vecs.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        v.pix  = img[y][x];
        v.emit = (x >= 2) && (y >= 2);
        v.win  = v.emit ? model_win(x - 1, y - 1) : 9'd0;
        v.x    = 8'(x - 1);
        v.y    = 8'(y - 1);
        v.last = (x == w - 1) && (y == h - 1);
        vecs.push_back(v);
      end
  endtask

  task automatic drive(input bit sel, input bit sf, input bit pv, input bit pix);
    @(posedge clk);
    #1;
    if (sel) begin
      ifb.startFrame = sf; ifb.pixelValid = pv; ifb.pixelIn = pix;
    end else begin
      ifa.startFrame = sf; ifa.pixelValid = pv; ifa.pixelIn = pix;
    end
  endtask

  task automatic start_frame(input bit sel);
    drive(sel, 1'b1, 1'b0, 1'b0);
    drive(sel, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check(sel ? "b_busy_after_start" : "a_busy_after_start",
          32'(sel ? ifb.busy : ifa.busy), 32'd1);
  endtask

  task automatic feed(input bit sel, input int max_gap, input int restart_at, input int n_pix);
    exp_t e;
    int   gap;
    for (int i = 0; i < n_pix; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) drive(sel, 1'b0, 1'b0, 1'b0);
      drive(sel, i == restart_at, 1'b1, vecs[i].pix);
      if (vecs[i].emit) begin
        e.win  = vecs[i].win;
        e.x    = vecs[i].x;
        e.y    = vecs[i].y;
        e.done = vecs[i].last;
        e.cyc  = cyc + 1;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
      end
    end
  endtask

  // Checks the DONE cycle and the fall of busy; optionally issues the next startFrame
  // in the very first IDLE cycle.
  task automatic finish_frame(input bit sel, input bit b2b);
    drive(sel, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check(sel ? "b_done_cycle_frameDone" : "a_done_cycle_frameDone",
          32'(sel ? ifb.frameDone : ifa.frameDone), 32'd1);
    check(sel ? "b_done_cycle_busy" : "a_done_cycle_busy",
          32'(sel ? ifb.busy : ifa.busy), 32'd1);
    drive(sel, b2b, 1'b0, 1'b0);
    @(negedge clk);
    check(sel ? "b_idle_busy" : "a_idle_busy", 32'(sel ? ifb.busy : ifa.busy), 32'd0);
    check(sel ? "b_idle_frameDone" : "a_idle_frameDone",
          32'(sel ? ifb.frameDone : ifa.frameDone), 32'd0);
    drive(sel, 1'b0, 1'b0, 1'b0);
    check(sel ? "b_queue_drained" : "a_queue_drained",
          32'(sel ? q_b.size() : q_a.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ifa.windowValid) begin
        win_cnt_a++;
        check("a_window_expected", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          ea = q_a.pop_front();
          check("a_windowOut", 32'(ifa.windowOut), 32'(ea.win));
          check("a_xAddress", 32'(ifa.xAddress), 32'(ea.x));
          check("a_yAddress", 32'(ifa.yAddress), 32'(ea.y));
          check("a_frameDone", 32'(ifa.frameDone), 32'(ea.done));
          check("a_latency_cycle", 32'(cyc), 32'(ea.cyc));
        end
      end else if (ifa.frameDone) begin
        check("a_frameDone_without_window", 32'(ifa.frameDone), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (ifb.windowValid) begin
        win_cnt_b++;
        last_x_b = ifb.xAddress;
        last_y_b = ifb.yAddress;
        check("b_window_expected", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          eb = q_b.pop_front();
          check("b_windowOut", 32'(ifb.windowOut), 32'(eb.win));
          check("b_xAddress", 32'(ifb.xAddress), 32'(eb.x));
          check("b_yAddress", 32'(ifb.yAddress), 32'(eb.y));
          check("b_frameDone", 32'(ifb.frameDone), 32'(eb.done));
          check("b_latency_cycle", 32'(cyc), 32'(eb.cyc));
        end
      end else if (ifb.frameDone) begin
        check("b_frameDone_without_window", 32'(ifb.frameDone), 32'd0);
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    win_cnt_a = 0; win_cnt_b = 0;
    last_x_b = '0; last_y_b = '0;
    reset = 1'b1;
    ifa.startFrame = 1'b0; ifa.pixelValid = 1'b0; ifa.pixelIn = 1'b0;
    ifb.startFrame = 1'b0; ifb.pixelValid = 1'b0; ifb.pixelIn = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("reset_windowOut", 32'(ifa.windowOut), 32'd0);
    check("reset_windowValid", 32'(ifa.windowValid), 32'd0);
    check("reset_xAddress", 32'(ifa.xAddress), 32'd0);
    check("reset_yAddress", 32'(ifa.yAddress), 32'd0);
    check("reset_frameDone", 32'(ifa.frameDone), 32'd0);
    check("reset_busy", 32'(ifa.busy), 32'd0);
    check("reset_b_busy", 32'(ifb.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // All-ones frame, continuous, then back-to-back into the single-pixel frame.
    fill_img(5, 5, 0);
    build_vectors(5, 5);
    win_cnt_a = 0;
    start_frame(1'b0);
    feed(1'b0, 0, -1, 25);
    fill_img(5, 5, 1);
    finish_frame(1'b0, 1'b1);
    check("ones_window_count", 32'(win_cnt_a), 32'd9);

    // Single 1 at (2,2), started by the back-to-back startFrame above.
    build_vectors(5, 5);
    win_cnt_a = 0;
    feed(1'b0, 0, -1, 25);
    finish_frame(1'b0, 1'b0);
    check("single_window_count", 32'(win_cnt_a), 32'd9);

    // Same frame with random 0..3 cycle gaps between pixels.
    win_cnt_a = 0;
    start_frame(1'b0);
    feed(1'b0, 3, -1, 25);
    finish_frame(1'b0, 1'b0);
    check("gaps_window_count", 32'(win_cnt_a), 32'd9);

    // Abort after 12 pixels with an asynchronous mid-cycle reset.
    fill_img(5, 5, 0);
    build_vectors(5, 5);
    win_cnt_a = 0;
    start_frame(1'b0);
    feed(1'b0, 0, -1, 12);
    #2;
    check("abort_busy_before_reset", 32'(ifa.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async_windowOut", 32'(ifa.windowOut), 32'd0);
    check("async_windowValid", 32'(ifa.windowValid), 32'd0);
    check("async_xAddress", 32'(ifa.xAddress), 32'd0);
    check("async_yAddress", 32'(ifa.yAddress), 32'd0);
    check("async_frameDone", 32'(ifa.frameDone), 32'd0);
    check("async_busy", 32'(ifa.busy), 32'd0);
    ifa.pixelValid = 1'b0;
    ifa.pixelIn    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_no_windows", 32'(win_cnt_a), 32'd0);
    start_frame(1'b0);
    feed(1'b0, 0, -1, 25);
    finish_frame(1'b0, 1'b0);
    check("after_abort_window_count", 32'(win_cnt_a), 32'd9);

    // pixelValid pulses in IDLE are ignored; startFrame during RUN does not restart.
    fill_img(5, 5, 2);
    build_vectors(5, 5);
    win_cnt_a = 0;
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_pixels_busy", 32'(ifa.busy), 32'd0);
    check("idle_pixels_no_window", 32'(win_cnt_a), 32'd0);
    start_frame(1'b0);
    feed(1'b0, 1, 7, 25);
    finish_frame(1'b0, 1'b0);
    check("restart_ignored_window_count", 32'(win_cnt_a), 32'd9);

    // Widest legal row, minimum height.
    fill_img(256, 3, 2);
    build_vectors(256, 3);
    win_cnt_b = 0;
    start_frame(1'b1);
    feed(1'b1, 0, -1, 768);
    finish_frame(1'b1, 1'b0);
    check("wide_window_count", 32'(win_cnt_b), 32'd254);
    check("wide_last_x", 32'(last_x_b), 32'd254);
    check("wide_last_y", 32'(last_y_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_window_3x3.md
# event_window_3x3

Upstream neighbour of the median filter: converts a raster-order stream of 1-bit event pixels into 3x3 binary neighbourhood windows. Each window is tagged with the image coordinates of its centre pixel. Two internal line buffers hold the previous two rows. Windows are produced for interior centres only; the filter counts the set bits in each window to decide its output.

## Interface
Parameters:
- IMG_WIDTH, 128, pixels per row; legal range 3..256.
- IMG_HEIGHT, 128, rows per frame; legal range 3..256.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- startFrame  in  1  one-cycle pulse that arms capture of a new frame.
- pixelValid  in  1  pixelIn is valid this cycle.
- pixelIn  in  1  event pixel value, raster order (row 0 col 0 first).
- windowOut  out  9  3x3 window; bit index = 3*dy + dx, where dy/dx = 0 is the top row/left column; bit 4 is the centre.
- windowValid  out  1  windowOut, xAddress and yAddress are valid (one-cycle pulse per window).
- xAddress  out  8  column of the window centre.
- yAddress  out  8  row of the window centre.
- frameDone  out  1  one-cycle pulse at the end of a frame.
- busy  out  1  a frame is in progress.

## Operation
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: startFrame=1 -> RUN; clears col/row counters to 0. pixelValid is ignored in IDLE.
  - RUN: each pixelValid=1 cycle accepts one pixel at (col,row). col increments; when col = IMG_WIDTH-1, col wraps to 0 and row increments.
  - RUN -> DONE: on acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
  - startFrame in RUN or DONE is ignored.
  - DONE: unconditionally -> IDLE after one cycle.
- Line buffers: lb0 holds row r-2 and lb1 holds row r-1, IMG_WIDTH bits each. On acceptance at column c:
  - lb0[c] <= lb1[c];
  - lb1[c] <= pixelIn;
  - the 3-column shift register shifts in the new column {lb0[c], lb1[c], pixelIn} (top, middle, bottom).
- A window is emitted for an accepted pixel at (c,r) when c >= 2 and r >= 2.
  - Window spans columns c-2..c and rows r-2..r; xAddress = c-1, yAddress = r-1.
  - Emission count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2), in raster order of centres.
- No border windows are produced; centres on row/column 0 or the last row/column are never reported.
- Line buffers and the shift register are not reset. Stale contents are never emitted, because of the c >= 2 / r >= 2 gate.
- Gaps in pixelValid stall the pipeline without loss; there is no backpressure, so the consumer must accept one window per cycle.
- Counters are 8-bit with explicit wrap at IMG_WIDTH-1 / IMG_HEIGHT-1; no reliance on natural overflow.

## Timing
- Reset values: windowOut=0, windowValid=0, xAddress=0, yAddress=0, frameDone=0, busy=0, state=IDLE.
- All outputs are registered.
- startFrame sampled at edge k -> busy=1 from cycle k+1. The first pixel may be presented at cycle k+1.
- Window latency: a pixel accepted at edge t gives windowValid=1 with its data during cycle t+1, for exactly one cycle.
- frameDone=1 during the same cycle as the final windowValid (state DONE). busy stays 1 in that cycle and drops to 0 the next cycle.
- Back-to-back frames: a startFrame in the first IDLE cycle after DONE is accepted.
- Reset asserted mid-frame: all outputs are 0 immediately (asynchronous). The partial frame is discarded, and no windowValid or frameDone is produced for it.

## Test plan
(IMG_WIDTH = IMG_HEIGHT = 5 unless noted.)
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 without waiting for a clock edge; state IDLE.
- All-ones frame with continuous pixelValid -> exactly 9 windows, all 0x1FF, with centres (1,1),(2,1),(3,1),(1,2)...(3,3). frameDone coincides with the (3,3) window, and busy falls one cycle later.
- Single 1 at (2,2), all else 0 -> window at centre (1,1)=0x100, (2,1)=0x080, (3,1)=0x040, (1,2)=0x020, (2,2)=0x010, (3,2)=0x008, (1,3)=0x004, (2,3)=0x002, (3,3)=0x001.
- Same as the single-pixel scenario with random pixelValid gaps of 0-3 cycles -> identical window sequence; each windowValid follows its triggering pixel by exactly 1 cycle.
- Reset after 12 pixels, then startFrame and an all-ones frame -> no output from the aborted frame; the new frame gives 9 windows of 0x1FF.
- pixelValid pulses while in IDLE, plus startFrame asserted at pixel 7 of RUN -> IDLE pixels are ignored, the frame is not restarted, and 9 windows are output; also repeat with IMG_WIDTH=256, IMG_HEIGHT=3 -> 254 windows, last centre (254,1).
